// File: rtl/sound_pkg.sv
// ---------------------------------------------------------------------------
// sound_pkg : shared types and widths for the audio record/playback path
// Revision  : 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package sound_pkg;

  localparam int SAMPLE_W = 16;
  localparam int ADDR_W   = 16;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RECORD = 2'd1,
    DONE   = 2'd2
  } rec_state_t;

endpackage

`default_nettype wire

// File: rtl/pdm_clk_gen.sv
// ---------------------------------------------------------------------------
// pdm_clk_gen : free-running PDM microphone clock with a one-cycle rise strobe
// Revision    : 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module pdm_clk_gen #(
  parameter int HALF_DIV = 20
) (
  input  logic clk,
  input  logic rst,
  output logic mic_clk,
  output logic rise
);

  localparam int CW = (HALF_DIV > 1) ? $clog2(HALF_DIV) : 1;
  localparam logic [CW-1:0] HALF_LAST = CW'(HALF_DIV - 1);

  logic [CW-1:0] half_cnt;
  logic          at_end;

  assign at_end = (half_cnt == HALF_LAST);
  // Strobe marks the cycle whose closing edge drives mic_clk 0->1.
  assign rise   = at_end & ~mic_clk;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      half_cnt <= '0;
      mic_clk  <= 1'b0;
    end else if (at_end) begin
      half_cnt <= '0;
      mic_clk  <= ~mic_clk;
    end else begin
      half_cnt <= half_cnt + CW'(1);
    end
  end

endmodule

`default_nettype wire

// File: rtl/sound_recorder.sv
// ---------------------------------------------------------------------------
// sound_recorder : PDM capture, ones-count decimation, sample RAM writer
// Revision       : 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module sound_recorder
  import sound_pkg::*;
#(
  parameter int HALF_DIV = 20,
  parameter int DECIM    = 512,
  parameter int DEPTH    = 65536
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                sw_rec,
  output logic                mic_clk,
  output logic                mic_lrsel,
  input  logic                mic_data,
  output logic [ADDR_W-1:0]   data_addr,
  output logic [SAMPLE_W-1:0] data_dout,
  output logic                data_we,
  output logic                busy,
  output logic                done
);

  localparam int BW = (DECIM > 1) ? $clog2(DECIM) : 1;
  localparam int OW = $clog2(DECIM + 1);
  localparam int IW = 17;
  localparam logic [BW-1:0] LAST_BIT = BW'(DECIM - 1);
  localparam logic [IW-1:0] LAST_IDX = IW'(DEPTH - 1);

  rec_state_t     state;
  logic [1:0]     sw_sync;
  logic           sw_prev;
  logic           start;
  logic           rise;
  logic [BW-1:0]  bit_cnt;
  logic [OW-1:0]  ones;
  logic [OW-1:0]  ones_sum;
  logic [IW-1:0]  index;
  logic [IW-1:0]  index_nxt;

  pdm_clk_gen #(
    .HALF_DIV (HALF_DIV)
  ) u_clk_gen (
    .clk     (clk),
    .rst     (rst),
    .mic_clk (mic_clk),
    .rise    (rise)
  );

  assign mic_lrsel = 1'b0;
  assign start     = sw_sync[1] & ~sw_prev;
  assign ones_sum  = ones + OW'(mic_data);
  assign index_nxt = index + IW'(1);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sw_sync   <= '0;
      sw_prev   <= 1'b0;
      state     <= IDLE;
      bit_cnt   <= '0;
      ones      <= '0;
      index     <= '0;
      data_addr <= '0;
      data_dout <= '0;
      data_we   <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      sw_sync <= {sw_sync[0], sw_rec};
      sw_prev <= sw_sync[1];
      case (state)
        IDLE, DONE: begin
          if (start) begin
            state     <= RECORD;
            busy      <= 1'b1;
            done      <= 1'b0;
            bit_cnt   <= '0;
            ones      <= '0;
            index     <= '0;
            data_addr <= '0;
          end
        end
        RECORD: begin
          // The write cycle never overlaps a strobe: strobes are >= 2 cycles apart.
          if (data_we) begin
            data_we <= 1'b0;
            if (index == LAST_IDX) begin
              state <= DONE;
              busy  <= 1'b0;
              done  <= 1'b1;
            end else begin
              index     <= index_nxt;
              data_addr <= index_nxt[ADDR_W-1:0];
            end
          end else if (rise) begin
            if (bit_cnt == LAST_BIT) begin
              data_we   <= 1'b1;
              data_dout <= SAMPLE_W'(ones_sum);
              data_addr <= index[ADDR_W-1:0];
              bit_cnt   <= '0;
              ones      <= '0;
            end else begin
              bit_cnt <= bit_cnt + BW'(1);
              ones    <= ones_sum;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_sound_recorder.sv
// ---------------------------------------------------------------------------
// tb_sound_recorder : randomized bench with a cycle-level reference model
// Revision          : 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_sound_recorder;

  localparam int H = 2;
  localparam int D = 8;
  localparam int N = 4;

  localparam int M_ZERO = 0;
  localparam int M_ONES = 1;
  localparam int M_ALT  = 2;
  localparam int M_RAND = 3;

  logic        clk;
  logic        rst;
  logic        sw_rec;
  logic        mic_clk;
  logic        mic_lrsel;
  logic        mic_data;
  logic [15:0] data_addr;
  logic [15:0] data_dout;
  logic        data_we;
  logic        busy;
  logic        done;

  sound_recorder #(
    .HALF_DIV (H),
    .DECIM    (D),
    .DEPTH    (N)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .sw_rec    (sw_rec),
    .mic_clk   (mic_clk),
    .mic_lrsel (mic_lrsel),
    .mic_data  (mic_data),
    .data_addr (data_addr),
    .data_dout (data_dout),
    .data_we   (data_we),
    .busy      (busy),
    .done      (done)
  );

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;
  int mode     = M_ZERO;
  bit chk_en   = 1'b0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc++;

  // Reference model: cycles since reset give mic_clk; recording collects
  // rise-sampled bits into a queue and emits their sum per DECIM bits.
  int       t;
  int       rcount;
  bit       m_mic, m_rec, m_done, m_we;
  int       m_idx;
  int       m_addr, m_dout;
  bit       h1, h2, h3;
  int       q[$];

  always @(posedge clk or posedge rst) begin
    bit st;
    bit rs;
    int sum;
    if (rst) begin
      t = 0; rcount = 0;
      m_mic = 0; m_rec = 0; m_done = 0; m_we = 0;
      m_idx = 0; m_addr = 0; m_dout = 0;
      h1 = 0; h2 = 0; h3 = 0;
      q.delete();
    end else begin
      st = h2 & ~h3;
      h3 = h2; h2 = h1; h1 = sw_rec;
      t++;
      rs    = (t % (2 * H)) == H;
      m_mic = ((t / H) % 2) == 1;
      if (rs) rcount++;
      if (m_we) begin
        m_we = 0;
        m_idx++;
        if (m_idx == N) begin
          m_rec  = 0;
          m_done = 1;
        end else begin
          m_addr = m_idx;
        end
      end else if (m_rec) begin
        if (rs) begin
          q.push_back(int'(mic_data));
          if (q.size() == D) begin
            sum = 0;
            foreach (q[i]) sum += q[i];
            q.delete();
            m_we   = 1;
            m_dout = sum;
            m_addr = m_idx;
          end
        end
      end else if (st) begin
        m_rec  = 1;
        m_done = 0;
        m_idx  = 0;
        m_addr = 0;
        q.delete();
      end
    end
  end

  // Stimulus for mic_data, updated away from the active edge.
  always @(negedge clk) begin
    case (mode)
      M_ONES:  mic_data = 1'b1;
      M_ALT:   mic_data = rcount[0];
      M_RAND:  mic_data = 1'($urandom_range(0, 1));
      default: mic_data = 1'b0;
    endcase
  end

  always @(negedge clk) begin
    if (chk_en) begin
      checks++;
      if ({mic_clk, mic_lrsel, data_we, busy, done} !== {m_mic, 1'b0, m_we, m_rec, m_done} ||
          data_addr !== 16'(m_addr) || data_dout !== 16'(m_dout)) begin
        failures++;
        $display("FAIL cycle_cmp t=%0t act{clk,lr,we,busy,done}=%b addr=%0d dout=%0d exp=%b addr=%0d dout=%0d",
                 $time, {mic_clk, mic_lrsel, data_we, busy, done}, data_addr, data_dout,
                 {m_mic, 1'b0, m_we, m_rec, m_done}, m_addr, m_dout);
      end
    end
  end

  typedef struct {
    int c;
    int addr;
    int dout;
  } wr_t;
  wr_t log_q[$];

  always @(negedge clk) begin
    wr_t w;
    if (!rst && data_we === 1'b1) begin
      w.c = cyc; w.addr = int'(data_addr); w.dout = int'(data_dout);
      log_q.push_back(w);
    end
  end

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  task automatic pulse();
    @(negedge clk) sw_rec = 1'b1;
    repeat (6) @(negedge clk);
    sw_rec = 1'b0;
  endtask

  task automatic wait_done(input int budget);
    int n = 0;
    while (done !== 1'b1 && n < budget) begin
      @(negedge clk);
      n++;
    end
    check("wait_done", int'(done), 1);
  endtask

  task automatic check_rec(input int expd, input bit chk_dout);
    check("write_count", log_q.size(), N);
    for (int i = 0; i < log_q.size() && i < N; i++) begin
      check("write_addr", log_q[i].addr, i);
      if (chk_dout) check("write_dout", log_q[i].dout, expd);
      if (i > 0) check("write_spacing", log_q[i].c - log_q[i-1].c, 2 * H * D);
    end
  endtask

  initial begin
    int pat[8];
    int n;
    pat = '{0, 1, 1, 0, 0, 1, 1, 0};
    rst = 1'b1; sw_rec = 1'b0; mic_data = 1'b0;
    chk_en = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_mic_clk", int'(mic_clk), 0);
    check("rst_addr", int'(data_addr), 0);
    check("rst_dout", int'(data_dout), 0);
    check("rst_we_busy_done", int'({data_we, busy, done, mic_lrsel}), 0);
    rst = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      check("mic_clk_wave", int'(mic_clk), pat[i]);
    end

    // Constant ones: every sample is DECIM.
    mode = M_ONES; log_q.delete();
    pulse();
    wait_done(400);
    repeat (60) @(negedge clk);
    check_rec(8, 1'b1);
    check("done_addr", int'(data_addr), N - 1);
    check("done_busy", int'(busy), 0);

    mode = M_ALT; log_q.delete();
    pulse();
    wait_done(400);
    check_rec(4, 1'b1);

    mode = M_ZERO; log_q.delete();
    pulse();
    wait_done(400);
    check_rec(0, 1'b1);

    // Held switch must not retrigger after completion.
    mode = M_ONES; log_q.delete();
    @(negedge clk) sw_rec = 1'b1;
    repeat (6) @(negedge clk);
    wait_done(400);
    repeat (100) @(negedge clk);
    check("hold_no_restart", log_q.size(), N);
    check("hold_done", int'(done), 1);
    sw_rec = 1'b0;
    repeat (5) @(negedge clk);
    log_q.delete();
    sw_rec = 1'b1;
    repeat (6) @(negedge clk);
    check("restart_done_low", int'(done), 0);
    check("restart_busy", int'(busy), 1);
    wait_done(400);
    check_rec(8, 1'b1);
    sw_rec = 1'b0;

    // Switch activity mid-recording is ignored; data is random.
    mode = M_RAND; log_q.delete();
    pulse();
    for (int i = 0; i < 4; i++) begin
      repeat (5) @(negedge clk) sw_rec = ~sw_rec;
    end
    sw_rec = 1'b0;
    wait_done(400);
    repeat (20) @(negedge clk);
    check_rec(0, 1'b0);

    // Reset after the second write discards the recording.
    mode = M_ONES; log_q.delete();
    pulse();
    n = 0;
    while (log_q.size() < 2 && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("two_writes_seen", log_q.size(), 2);
    repeat (3) @(negedge clk);
    @(posedge clk);
    #3 rst = 1'b1;
    #1;
    check("midrst_busy", int'(busy), 0);
    check("midrst_we", int'(data_we), 0);
    check("midrst_addr", int'(data_addr), 0);
    check("midrst_mic_clk", int'(mic_clk), 0);
    @(negedge clk) rst = 1'b0;
    repeat (200) @(negedge clk);
    check("no_writes_after_rst", log_q.size(), 2);
    check("idle_after_rst", int'({busy, done}), 0);
    mode = M_RAND; log_q.delete();
    pulse();
    wait_done(400);
    check_rec(0, 1'b0);

    repeat (5) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog simulation time limit reached checks=%0d", checks);
    $fatal(1, "watchdog");
  end

endmodule

`default_nettype wire
